split_bus_arbiter: RTL and testbench

Arbiter and split-transaction scheduler for the serial bus. It shares the bus between initiator 0, initiator 1 and the split target's data-return path. It grants initiators round-robin and parks an initiator whose transaction was split. It hands the bus to the split target when return data is ready and routes the return to the parked owner. It sits inside `bus`, between the initiator ports, the split-target port and the address decoder.

---
 rtl/split_bus_arbiter_pkg.sv | 19 +
 rtl/split_bus_arbiter_timer.sv | 50 +++++
 rtl/split_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_split_bus_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/split_bus_arbiter_pkg.sv
// Shared definitions for the split-transaction bus arbiter.
//   arb_state_t           : arbiter FSM state encoding
//   OWNER_INIT0/1         : initiator index values carried on split_owner
//   DEFAULT_GRANT_TIMEOUT : default watchdog limit in cycles (0 disables)
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GNT0      = 2'd1,
        GNT1      = 2'd2,
        SPLIT_RET = 2'd3
    } arb_state_t;

    localparam logic OWNER_INIT0 = 1'b0;
    localparam logic OWNER_INIT1 = 1'b1;

    localparam int unsigned DEFAULT_GRANT_TIMEOUT = 32'd256;

endpackage

// File: rtl/split_bus_arbiter_timer.sv
// Grant watchdog counter: clears on clr_i, counts while en_i, saturates at
// LIMIT. expired_o flags the cycle in which the current grant has been held
// for LIMIT cycles, so a grant is never high for more than LIMIT cycles.
// LIMIT = 0 disables the watchdog (expired_o stays low).
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : restart the count (held while the bus is idle)
//   en_i       : a grant is being held this cycle
//   expired_o  : the grant limit is reached this cycle
module arb_grant_timer #(
    parameter int unsigned LIMIT = 32'd256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = (LIMIT > 32'd0) ? $clog2(LIMIT + 32'd1) : 32'd1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(LIMIT);
    localparam logic [CW-1:0] CNT_LAST = (LIMIT > 32'd0) ? CW'(LIMIT - 32'd1) : '0;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts completed cycles of the grant, so LIMIT-1 marks the last one.
    assign expired_o = (LIMIT != 32'd0) && en_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/split_bus_arbiter.sv
// Arbiter and split-transaction scheduler for the serial bus. Shares the bus
// between initiator 0, initiator 1 and the split target's return path.
// Initiators are granted round-robin; an initiator that receives a split
// acknowledge is parked until the split target returns its data.
//   GRANT_TIMEOUT            : max cycles a grant may be held (0 = no watchdog)
//   clk, rst_n               : bus clock, asynchronous active-low reset
//   init0_req, init1_req     : initiator requests (level)
//   split_req                : split target wants to return data (level)
//   split_ack                : split acknowledge pulse to the current owner
//   init0_grant, init1_grant : initiator grants
//   split_grant              : grant to the split return path
//   split_owner(_valid)      : parked initiator index and its valid flag
//   split_waiting_for_return : split parked, return not yet granted
//   backward_sel             : backward-path mux select
//   bus_busy                 : any grant high
//   timeout_err, split_err   : one-cycle error pulses
module split_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned GRANT_TIMEOUT = DEFAULT_GRANT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic init0_req,
    input  logic init1_req,
    input  logic split_req,
    input  logic split_ack,
    output logic init0_grant,
    output logic init1_grant,
    output logic split_grant,
    output logic split_owner,
    output logic split_owner_valid,
    output logic split_waiting_for_return,
    output logic backward_sel,
    output logic bus_busy,
    output logic timeout_err,
    output logic split_err
);

    arb_state_t state_q, state_d;
    logic       rr_last_q, rr_last_d;
    logic       owner_q, owner_d;
    logic       owner_valid_q, owner_valid_d;
    logic [1:0] mask_q, mask_d;
    logic       timeout_err_q, timeout_err_d;
    logic       split_err_q, split_err_d;

    logic       elig0_s;
    logic       elig1_s;
    logic       split_elig_s;
    logic       cur_idx_s;
    logic       cur_req_s;
    logic       expired_s;

    arb_grant_timer #(
        .LIMIT (GRANT_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q == IDLE),
        .en_i      (state_q != IDLE),
        .expired_o (expired_s)
    );

    assign elig0_s = init0_req && !(owner_valid_q && (owner_q == OWNER_INIT0)) && !mask_q[0];
    assign elig1_s = init1_req && !(owner_valid_q && (owner_q == OWNER_INIT1)) && !mask_q[1];
    assign split_elig_s = split_req && owner_valid_q;

    // Index and request of the initiator holding the bus (meaningful in GNTx).
    assign cur_idx_s = (state_q == GNT1) ? OWNER_INIT1 : OWNER_INIT0;
    assign cur_req_s = (state_q == GNT1) ? init1_req : init0_req;

    // Next-state, round-robin pointer, split bookkeeping and error pulses.
    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        // A timeout mask lasts only until the initiator drops its request.
        mask_d        = mask_q & {init1_req, init0_req};
        timeout_err_d = 1'b0;
        split_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (split_elig_s) begin
                    state_d = SPLIT_RET;
                end else if (elig0_s && (!elig1_s || (rr_last_q == OWNER_INIT1))) begin
                    state_d   = GNT0;
                    rr_last_d = OWNER_INIT0;
                end else if (elig1_s) begin
                    state_d   = GNT1;
                    rr_last_d = OWNER_INIT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0, GNT1: begin
                // A split wins over a coincident request drop.
                if (split_ack) begin
                    state_d = IDLE;
                    if (owner_valid_q) begin
                        split_err_d = 1'b1;
                    end else begin
                        owner_d       = cur_idx_s;
                        owner_valid_d = 1'b1;
                    end
                end else if (!cur_req_s) begin
                    state_d = IDLE;
                end else if (expired_s) begin
                    state_d           = IDLE;
                    mask_d[cur_idx_s] = 1'b1;
                    timeout_err_d     = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            SPLIT_RET: begin
                // Either way the return is over and the parked owner is freed.
                if (!split_req || expired_s) begin
                    state_d       = IDLE;
                    owner_valid_d = 1'b0;
                    timeout_err_d = split_req;
                end else begin
                    state_d = SPLIT_RET;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_last_q     <= OWNER_INIT1;
            owner_q       <= OWNER_INIT0;
            owner_valid_q <= 1'b0;
            mask_q        <= 2'b00;
            timeout_err_q <= 1'b0;
            split_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            mask_q        <= mask_d;
            timeout_err_q <= timeout_err_d;
            split_err_q   <= split_err_d;
        end
    end

    assign init0_grant              = (state_q == GNT0);
    assign init1_grant              = (state_q == GNT1);
    assign split_grant              = (state_q == SPLIT_RET);
    assign split_owner              = owner_q;
    assign split_owner_valid        = owner_valid_q;
    assign split_waiting_for_return = owner_valid_q && (state_q != SPLIT_RET);
    assign backward_sel             = (state_q == SPLIT_RET) ? owner_q : (state_q == GNT1);
    assign bus_busy                 = (state_q != IDLE);
    assign timeout_err              = timeout_err_q;
    assign split_err                = split_err_q;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Randomized and directed stimulus for split_bus_arbiter. Each driven cycle
// runs a transaction-level reference model and queues the expected outputs;
// an independent monitor pops and compares after every clock edge.
module tb_split_bus_arbiter;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init0_req = 1'b0;
    logic init1_req = 1'b0;
    logic split_req = 1'b0;
    logic split_ack = 1'b0;
    logic init0_grant, init1_grant, split_grant, split_owner, split_owner_valid;
    logic split_waiting_for_return, backward_sel, bus_busy, timeout_err, split_err;

    split_bus_arbiter #(.GRANT_TIMEOUT(TO)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .init0_req                (init0_req),
        .init1_req                (init1_req),
        .split_req                (split_req),
        .split_ack                (split_ack),
        .init0_grant              (init0_grant),
        .init1_grant              (init1_grant),
        .split_grant              (split_grant),
        .split_owner              (split_owner),
        .split_owner_valid        (split_owner_valid),
        .split_waiting_for_return (split_waiting_for_return),
        .backward_sel             (backward_sel),
        .bus_busy                 (bus_busy),
        .timeout_err              (timeout_err),
        .split_err                (split_err)
    );

    always #5 clk = ~clk;

    // Field order: g0 g1 sg owner owner_valid waiting bsel busy terr serr
    typedef logic [9:0] outv_t;

    outv_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who holds the bus (-1 nobody, 0/1 initiator, 2 split
    // return), who is parked (-1 nobody), who wins the next tie, how long the
    // current grant has been held, and which initiators are timeout-masked.
    int m_owner  = -1;
    int m_parked = -1;
    int m_lastso = 0;
    int m_pref   = 0;
    int m_held   = 0;
    bit m_mask[2];

    function automatic outv_t actual_out();
        return {init0_grant, init1_grant, split_grant, split_owner, split_owner_valid,
                split_waiting_for_return, backward_sel, bus_busy, timeout_err, split_err};
    endfunction

    function automatic void model_reset();
        m_owner = -1; m_parked = -1; m_lastso = 0; m_pref = 0; m_held = 0;
        m_mask[0] = 1'b0; m_mask[1] = 1'b0;
    endfunction

    function automatic outv_t model_step(input bit r0, input bit r1, input bit sr, input bit sa);
        bit req[2];
        bit ok[2];
        bit terr, serr, sg, sov;
        int pick, x;
        req[0] = r0; req[1] = r1;
        terr = 1'b0; serr = 1'b0;
        for (int i = 0; i < 2; i++) if (!req[i]) m_mask[i] = 1'b0;
        if (m_owner == -1) begin
            if (sr && m_parked != -1) begin
                m_owner = 2; m_held = 1;
            end else begin
                for (int i = 0; i < 2; i++) ok[i] = req[i] && (m_parked != i) && !m_mask[i];
                if (ok[0] && ok[1]) pick = m_pref;
                else if (ok[0])     pick = 0;
                else if (ok[1])     pick = 1;
                else                pick = -1;
                if (pick >= 0) begin
                    m_owner = pick; m_pref = 1 - pick; m_held = 1;
                end
            end
        end else if (m_owner == 2) begin
            if (!sr) begin
                m_owner = -1; m_parked = -1;
            end else if (m_held >= TO) begin
                m_owner = -1; m_parked = -1; terr = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            x = m_owner;
            if (sa) begin
                if (m_parked != -1) serr = 1'b1;
                else begin m_parked = x; m_lastso = x; end
                m_owner = -1;
            end else if (!req[x]) begin
                m_owner = -1;
            end else if (m_held >= TO) begin
                m_owner = -1; m_mask[x] = 1'b1; terr = 1'b1;
            end else begin
                m_held++;
            end
        end
        sg  = (m_owner == 2);
        sov = (m_parked != -1);
        return {m_owner == 0, m_owner == 1, sg, m_lastso[0], sov, sov && !sg,
                sg ? m_lastso[0] : (m_owner == 1), m_owner != -1, terr, serr};
    endfunction

    task automatic drive(input bit r0, input bit r1, input bit sr, input bit sa);
        @(negedge clk);
        init0_req = r0; init1_req = r1; split_req = sr; split_ack = sa;
        sb_q.push_back(model_step(r0, r1, sr, sa));
    endtask

    task automatic drive_n(input int n, input bit r0, input bit r1, input bit sr);
        for (int k = 0; k < n; k++) drive(r0, r1, sr, 1'b0);
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (actual_out() !== 10'b0) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, actual_out(), 10'b0);
        end
    endtask

    // Monitor: compare the DUT against the oldest queued expectation after each edge.
    always @(posedge clk) begin
        outv_t exp_v;
        #1;
        if (rst_n && sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            n_checks++;
            if (actual_out() !== exp_v) begin
                n_fail++;
                $display("FAIL outputs t=%0t actual=%b required=%b (g0 g1 sg own ownv wait bsel busy terr serr)",
                         $time, actual_out(), exp_v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit r0, r1, sr;
        #2;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with turnaround cycles.
        drive_n(3, 1, 1, 0);
        drive_n(3, 0, 1, 0);
        drive_n(2, 0, 0, 0);
        drive_n(3, 1, 1, 0);
        drive_n(2, 0, 0, 0);

        // Split on initiator 0; parked initiator is not regranted.
        drive_n(2, 1, 0, 0);
        drive(1, 0, 0, 1);
        drive_n(3, 1, 0, 0);
        drive_n(3, 1, 1, 0);

        // Return requested while initiator 1 owns the bus.
        drive_n(2, 1, 1, 1);
        drive_n(3, 1, 0, 1);
        drive_n(3, 1, 0, 0);

        // Second split while one is pending.
        drive(1, 0, 0, 1);
        drive_n(2, 1, 1, 0);
        drive(1, 1, 0, 1);
        drive_n(2, 0, 0, 0);
        drive_n(3, 0, 0, 1);
        drive_n(2, 0, 0, 0);

        // Watchdog on a held grant, then mask until request cycles low.
        drive_n(12, 1, 0, 0);
        drive(0, 0, 0, 0);
        drive_n(3, 1, 0, 0);
        // Watchdog on a split return that never ends.
        drive(1, 0, 0, 1);
        drive_n(12, 0, 0, 1);
        drive_n(2, 0, 0, 0);

        // Asynchronous reset during a split return.
        drive_n(2, 1, 0, 0);
        drive(1, 0, 0, 1);
        drive_n(3, 0, 0, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset_in_split_ret");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_n(3, 0, 0, 1);

        // Randomized traffic.
        r0 = 1'b0; r1 = 1'b0; sr = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) r0 = !r0;
            if ($urandom_range(0, 5) == 0) r1 = !r1;
            if ($urandom_range(0, 7) == 0) sr = !sr;
            drive(r0, r1, sr, $urandom_range(0, 9) == 0);
        end
        drive_n(2, 0, 0, 0);

        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
